time_bar_ctrl: RTL
==================

Name: time_bar_ctrl

Overview:
Sequencer for the on-screen countdown time bar. Generates the bar's module_en, start and one_ms_tick controls, and gates ticks during pause. Consumes the bar's elapsed flag and issues game-over or level-complete events to the game FSM. Sits between the top-level game state machine and the time bar in the VGA pipeline. It carries no VGA bus signals.

Parameters:
TICKS_PER_MS, 40000, number of clk cycles per millisecond (40 MHz pixel clock).
ARM_CYCLES, 2, minimum number of cycles module_en is high before start may pulse. Must be 2 or more.
MS_W, 16, width of the round millisecond counter.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset (0 = reset).
game_active  in  1  level signal from the game FSM; 1 while a game is in progress.
first_jump  in  1  one-cycle pulse on the player's first jump of a level; starts the countdown.
pause_req  in  1  level signal; 1 freezes the countdown.
level_done  in  1  one-cycle pulse when the player reaches the level goal.
elapsed  in  1  from time_bar; high while the bar is exhausted.
module_en  out  1  to time_bar.
start  out  1  to time_bar; one-cycle pulse.
one_ms_tick  out  1  to time_bar; one-cycle pulse per ms, only while counting.
game_over  out  1  one-cycle pulse on timeout.
level_time_valid  out  1  one-cycle pulse; level_time is valid in that cycle and stays held afterwards.
level_time  out  MS_W  ms spent on the last completed level.
round_ms  out  MS_W  live ms count for the current level.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=S_IDLE.
  - All outputs 0, including level_time and round_ms.
  - Prescaler and arm counter cleared.
- All outputs are registered. Each output changes on the clock edge after the cause that drives it.
- States:
  - S_IDLE: module_en=0. If game_active=1, go to S_ARMED and clear the arm counter and round_ms.
  - S_ARMED: module_en=1. The arm counter increments each cycle and saturates at ARM_CYCLES.
    - first_jump with arm counter >= ARM_CYCLES: pulse start, clear the prescaler, go to S_RUN.
    - first_jump seen earlier is latched. start then fires in the first cycle the arm counter reaches ARM_CYCLES.
  - S_RUN: module_en=1.
    - The prescaler counts 0..TICKS_PER_MS-1. one_ms_tick=1 in the cycle the prescaler equals TICKS_PER_MS-1, then the prescaler wraps to 0.
    - round_ms increments on each tick and saturates at all-ones.
  - S_PAUSE: module_en=1. Prescaler and round_ms hold their values (not cleared) and one_ms_tick=0. When pause_req=0, return to S_RUN and continue from the held prescaler value.
  - S_TIMEOUT: module_en=1 so the bar stays in its exhausted display. game_over pulses for one cycle on entry only. Leave only when game_active=0.
  - S_DONE: lasts exactly one cycle.
    - module_en=0 so the time bar returns to its idle state.
    - level_time is loaded from round_ms and level_time_valid pulses.
    - Next state is S_ARMED if game_active=1 (round_ms and arm counter cleared), else S_IDLE.
- Transition priority, evaluated every cycle in RUN and PAUSE:
  1. game_active=0 goes to S_IDLE.
  2. elapsed=1 goes to S_TIMEOUT.
  3. level_done goes to S_DONE.
  4. pause_req: from S_RUN, pause_req=1 goes to S_PAUSE; from S_PAUSE, pause_req=0 returns to S_RUN.
- game_active=0 in any state goes to S_IDLE next cycle; module_en drops that cycle.
- A tick due in the same cycle as a transition out of S_RUN is still emitted and counted. No tick is emitted in any other state.
- elapsed and level_done in the same cycle: timeout wins, and level_time is not updated.
- level_done or pause_req in S_IDLE or S_ARMED: ignored. first_jump outside S_ARMED: ignored.
- Mid-run reset: outputs go to 0 immediately (asynchronous). The time bar sees module_en=0 and returns to its idle state.

Test Plan:
1. TICKS_PER_MS=4, ARM_CYCLES=2. game_active=1, first_jump 5 cycles later -> module_en=1 one cycle after game_active; start a single cycle; one_ms_tick every 4th cycle; round_ms 1,2,3...
2. first_jump in the very first S_ARMED cycle -> start delayed until the arm counter reaches 2; exactly one start pulse.
3. Run to round_ms=10, pause_req=1 for 20 cycles, then release -> no ticks during pause; round_ms stays 10; next tick arrives after the remaining prescaler cycles, not a full 4.
4. level_done at round_ms=7 -> level_time=7 with a 1-cycle level_time_valid; module_en low for exactly 1 cycle; then S_ARMED with round_ms=0.
5. elapsed=1 and level_done in the same cycle -> game_over single-cycle pulse; level_time unchanged; module_en stays 1 until game_active=0.
6. Assert rst=0 asynchronously mid-tick in S_RUN -> all outputs 0 before the next clk edge. After release with game_active=1 -> S_ARMED with a clean arm delay.

Source files
------------

// File: rtl/time_bar_ctrl.sv
// time_bar_ctrl - sequencer for the on-screen countdown time bar.
//
// Arms the time bar when a game becomes active, issues its start pulse on the
// player's first jump, feeds it one tick per millisecond while counting
// (frozen during pause), and turns the bar's elapsed flag or the level goal
// into game-over / level-complete events for the game FSM.
//
// Ports:
//   clk              system clock
//   rst              asynchronous reset, active low
//   game_active      1 while a game is in progress
//   first_jump       pulse: player's first jump of the level, starts countdown
//   pause_req        level: 1 freezes the countdown
//   level_done       pulse: player reached the level goal
//   elapsed          from time_bar: bar is exhausted
//   module_en        to time_bar: enable
//   start            to time_bar: one-cycle start pulse
//   one_ms_tick      to time_bar: one pulse per millisecond while counting
//   game_over        pulse on timeout
//   level_time_valid pulse: level_time updated this cycle
//   level_time       ms spent on the last completed level (held)
//   round_ms         live ms count of the current level
module time_bar_ctrl #(
    parameter int unsigned TICKS_PER_MS = 40000,
    parameter int unsigned ARM_CYCLES   = 2,
    parameter int unsigned MS_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            game_active,
    input  logic            first_jump,
    input  logic            pause_req,
    input  logic            level_done,
    input  logic            elapsed,
    output logic            module_en,
    output logic            start,
    output logic            one_ms_tick,
    output logic            game_over,
    output logic            level_time_valid,
    output logic [MS_W-1:0] level_time,
    output logic [MS_W-1:0] round_ms
);

    localparam int unsigned PS_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int unsigned ARM_W = $clog2(ARM_CYCLES + 1);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICKS_PER_MS - 1);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(ARM_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_PAUSE,
        S_TIMEOUT,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [ARM_W-1:0] arm_cnt;
    logic             jump_seen;
    logic [PS_W-1:0]  prescaler;
    logic [MS_W-1:0]  round_inc;

    logic arm_clear;
    logic do_start;
    logic tick_due;
    logic load_level;

    assign round_inc = (round_ms == '1) ? round_ms : round_ms + MS_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        arm_clear = 1'b0;
        do_start  = 1'b0;
        tick_due  = 1'b0;
        case (state)
            S_IDLE: begin
                if (game_active) begin
                    state_n   = S_ARMED;
                    arm_clear = 1'b1;
                end
            end
            S_ARMED: begin
                if (!game_active) begin
                    state_n = S_IDLE;
                end else if ((first_jump || jump_seen) && arm_cnt == ARM_MAX) begin
                    state_n  = S_RUN;
                    do_start = 1'b1;
                end
            end
            S_RUN, S_PAUSE: begin
                // A tick due in RUN is emitted even when leaving RUN this cycle.
                tick_due = (state == S_RUN) && (prescaler == PS_LAST);
                if (!game_active)   state_n = S_IDLE;
                else if (elapsed)   state_n = S_TIMEOUT;
                else if (level_done) state_n = S_DONE;
                else if (pause_req) state_n = S_PAUSE;
                else                state_n = S_RUN;
            end
            S_TIMEOUT: begin
                if (!game_active) state_n = S_IDLE;
            end
            S_DONE: begin
                if (game_active) begin
                    state_n   = S_ARMED;
                    arm_clear = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        load_level = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_cnt          <= '0;
            jump_seen        <= 1'b0;
            prescaler        <= '0;
            round_ms         <= '0;
            level_time       <= '0;
            module_en        <= 1'b0;
            start            <= 1'b0;
            one_ms_tick      <= 1'b0;
            game_over        <= 1'b0;
            level_time_valid <= 1'b0;
        end else begin
            if (arm_clear) begin
                arm_cnt   <= '0;
                jump_seen <= 1'b0;
            end else if (state == S_ARMED) begin
                if (arm_cnt != ARM_MAX) arm_cnt <= arm_cnt + ARM_W'(1);
                if (first_jump)         jump_seen <= 1'b1;
            end

            if (do_start)              prescaler <= '0;
            else if (state == S_RUN)   prescaler <= tick_due ? '0 : prescaler + PS_W'(1);

            if (arm_clear)     round_ms <= '0;
            else if (tick_due) round_ms <= round_inc;

            // The level time includes a tick landing on the completing cycle.
            if (load_level) level_time <= tick_due ? round_inc : round_ms;

            module_en        <= (state_n == S_ARMED) || (state_n == S_RUN) ||
                                (state_n == S_PAUSE) || (state_n == S_TIMEOUT);
            start            <= do_start;
            one_ms_tick      <= tick_due;
            game_over        <= (state_n == S_TIMEOUT) && (state != S_TIMEOUT);
            level_time_valid <= load_level;
        end
    end

endmodule
